// File: rtl/lcd_writer.sv
// Character-LCD write master: queues CPU characters/commands in a small FIFO and
// serialises them as timed lcd_wr strobes, inserting set-address words at line ends.
module lcd_writer #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_cmd,
    input  logic [7:0]  in_data,
    output logic        lcd_wr,
    output logic [11:0] lcd_dbus,
    output logic        busy,
    output logic [6:0]  cursor
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned MaxSP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MaxCyc = (MaxSP > HOLD_CYCLES) ? MaxSP : HOLD_CYCLES;
    localparam int unsigned CW     = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

    // FIFO storage and wrap-bit pointers
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          full, empty, push, pop;
    logic [8:0]    head;

    // Bus FSM state
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [11:0]   dbus_q, dbus_d;
    logic [6:0]    cursor_q, cursor_d;
    logic          pend_q, pend_d;
    logic [6:0]    tgt_q, tgt_d;
    logic [6:0]    cursor_inc;
    logic          launch;

    assign full     = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign empty    = (wptr_q == rptr_q);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign head     = mem_q[rptr_q[AW-1:0]];

    assign lcd_wr   = wr_q;
    assign lcd_dbus = dbus_q;
    assign cursor   = cursor_q;
    assign busy     = (state_q != StIdle) | ~empty | pend_q;

    assign cursor_inc = cursor_q + 7'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {in_cmd, in_data};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        dbus_d   = dbus_q;
        cursor_d = cursor_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;
        pop      = 1'b0;
        launch   = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = 1'b1;
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = CW'(PULSE_CYCLES - 1);
                    wr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    wr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    launch = 1'b1;
                    // A pending wrap is always the very next transaction after it is
                    // set, so any non-character transaction ending here clears it.
                    pend_d = 1'b0;
                    if (!dbus_q[8]) begin
                        cursor_d = cursor_inc;
                        if (cursor_inc == 7'd16) begin
                            pend_d = 1'b1;
                            tgt_d  = 7'd64;
                        end else if (cursor_inc == 7'd80) begin
                            pend_d = 1'b1;
                            tgt_d  = 7'd0;
                        end
                    end else if (dbus_q[7]) begin
                        cursor_d = dbus_q[6:0];
                    end else if (dbus_q[0]) begin
                        cursor_d = 7'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Shared IDLE dispatch, also taken at HOLD end for back-to-back transfers
        if (launch) begin
            if (pend_d) begin
                dbus_d  = {3'b000, 1'b1, 1'b1, tgt_d};
                state_d = StSetup;
                cnt_d   = CW'(SETUP_CYCLES - 1);
            end else if (!empty) begin
                pop     = 1'b1;
                dbus_d  = {3'b000, head};
                state_d = StSetup;
                cnt_d   = CW'(SETUP_CYCLES - 1);
            end else begin
                state_d = StIdle;
            end
        end

        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            dbus_q   <= '0;
            cursor_q <= '0;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            dbus_q   <= dbus_d;
            cursor_q <= cursor_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

endmodule

// File: tb/tb_lcd_writer.sv
// Directed self-checking bench for lcd_writer: strobe timing, FIFO back-pressure,
// cursor tracking, automatic line wrap and asynchronous reset.
module tb_lcd_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_cmd = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        lcd_wr;
    logic [11:0] lcd_dbus;
    logic        busy;
    logic [6:0]  cursor;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    logic        saw_full = 1'b0;

    logic [11:0] bus_q[$];
    int unsigned rise_q[$];
    int unsigned width_q[$];
    logic        wr_prev = 1'b0;
    int unsigned hi = 0;

    lcd_writer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cmd   (in_cmd),
        .in_data  (in_data),
        .lcd_wr   (lcd_wr),
        .lcd_dbus (lcd_dbus),
        .busy     (busy),
        .cursor   (cursor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records the word on each lcd_wr rise, its cycle, and pulse width
    always @(negedge clk) begin
        if (lcd_wr && !wr_prev) begin
            bus_q.push_back(lcd_dbus);
            rise_q.push_back(cyc);
            hi = 1;
        end else if (lcd_wr) begin
            hi++;
        end else if (wr_prev) begin
            width_q.push_back(hi);
        end
        wr_prev = lcd_wr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        bus_q.delete();
        rise_q.delete();
        width_q.delete();
    endtask

    // Presents one word and returns at the negedge after the accepting edge, in_valid left high
    task automatic push(input logic cmd, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_data  = d;
        for (int i = 0; i < 500; i++) begin
            ok = in_ready;
            if (!in_ready) saw_full = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic cmd, input logic [7:0] d);
        push(cmd, d);
        in_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [11:0] exp_seq [18];

        // Reset state
        #1;
        chk("rst_wr", {31'd0, lcd_wr}, 32'd0);
        chk("rst_dbus", {20'd0, lcd_dbus}, 32'h000);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cursor", {25'd0, cursor}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single character, strobe timing relative to the push edge t
        push(1'b0, 8'h41);
        in_valid = 1'b0;
        chk("t1_busy_t", {31'd0, busy}, 32'd1);
        chk("t1_dbus_t", {20'd0, lcd_dbus}, 32'h000);
        @(negedge clk);
        chk("t1_dbus_pop", {20'd0, lcd_dbus}, 32'h041);
        chk("t1_wr_t1", {31'd0, lcd_wr}, 32'd0);
        @(negedge clk);
        chk("t1_wr_t2", {31'd0, lcd_wr}, 32'd0);
        @(negedge clk);
        chk("t1_wr_t3", {31'd0, lcd_wr}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_wr_t6", {31'd0, lcd_wr}, 32'd1);
        @(negedge clk);
        chk("t1_wr_t7", {31'd0, lcd_wr}, 32'd0);
        chk("t1_cur_t7", {25'd0, cursor}, 32'd0);
        @(negedge clk);
        chk("t1_busy_t8", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_busy_t9", {31'd0, busy}, 32'd0);
        chk("t1_cur_t9", {25'd0, cursor}, 32'd1);
        chk("t1_dbus_keep", {20'd0, lcd_dbus}, 32'h041);

        // 2: 17 characters streamed, auto wrap to 64 after column 16
        clear_logs();
        saw_full = 1'b0;
        send(1'b1, 8'h80);
        clear_logs();
        for (int i = 0; i < 17; i++) push(1'b0, 8'h41 + 8'(i));
        in_valid = 1'b0;
        wait_idle();
        chk("t2_backpressure", {31'd0, saw_full}, 32'd1);
        for (int i = 0; i < 16; i++) exp_seq[i] = 12'h041 + 12'(i);
        exp_seq[16] = 12'h1C0;
        exp_seq[17] = 12'h051;
        chk("t2_count", bus_q.size(), 32'd18);
        for (int i = 0; i < 18; i++) chk($sformatf("t2_word%0d", i), {20'd0, bus_q[i]},
                                         {20'd0, exp_seq[i]});
        for (int i = 1; i < 18; i++) chk($sformatf("t2_period%0d", i),
                                         rise_q[i] - rise_q[i-1], 32'd8);
        for (int i = 0; i < 18; i++) chk($sformatf("t2_width%0d", i), width_q[i], 32'd4);
        chk("t2_cursor", {25'd0, cursor}, 32'd65);

        // 3: 0x14F is a clear (bit7=0, bit0=1); set address 79 then a char wraps to 0
        clear_logs();
        send(1'b1, 8'h4F);
        chk("t3_clr_word", {20'd0, bus_q[$]}, 32'h14F);
        chk("t3_clr_cursor", {25'd0, cursor}, 32'd0);
        send(1'b1, 8'hCF);
        chk("t3_set79", {25'd0, cursor}, 32'd79);
        clear_logs();
        send(1'b0, 8'h5A);
        chk("t3_count", bus_q.size(), 32'd2);
        chk("t3_char", {20'd0, bus_q[0]}, 32'h05A);
        chk("t3_wrap", {20'd0, bus_q[1]}, 32'h180);
        chk("t3_cursor", {25'd0, cursor}, 32'd0);

        // 4: clear and a cursor-neutral command
        send(1'b1, 8'h85);
        chk("t4_set5", {25'd0, cursor}, 32'd5);
        send(1'b1, 8'h01);
        chk("t4_clr_word", {20'd0, bus_q[$]}, 32'h101);
        chk("t4_clr_cursor", {25'd0, cursor}, 32'd0);
        send(1'b1, 8'h85);
        send(1'b1, 8'h02);
        chk("t4_other_word", {20'd0, bus_q[$]}, 32'h102);
        chk("t4_other_cursor", {25'd0, cursor}, 32'd5);

        // 5: codes passed through unfiltered
        send(1'b0, 8'h07);
        chk("t5_w07", {20'd0, bus_q[$]}, 32'h007);
        chk("t5_c6", {25'd0, cursor}, 32'd6);
        send(1'b0, 8'hFF);
        chk("t5_wFF", {20'd0, bus_q[$]}, 32'h0FF);
        chk("t5_c7", {25'd0, cursor}, 32'd7);

        // Boundaries: 127 -> 0 without wrap; a command landing on 16 never wraps
        send(1'b1, 8'hFF);
        clear_logs();
        send(1'b0, 8'h20);
        chk("b127_count", bus_q.size(), 32'd1);
        chk("b127_cursor", {25'd0, cursor}, 32'd0);
        clear_logs();
        send(1'b1, 8'h90);
        chk("b16cmd_count", bus_q.size(), 32'd1);
        chk("b16cmd_cursor", {25'd0, cursor}, 32'd16);

        // 6: reset during PULSE with three entries still queued
        for (int i = 0; i < 4; i++) push(1'b0, 8'h61 + 8'(i));
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (lcd_wr) break;
            @(negedge clk);
        end
        chk("t6_in_pulse", {31'd0, lcd_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_wr", {31'd0, lcd_wr}, 32'd0);
        chk("t6_dbus", {20'd0, lcd_dbus}, 32'h000);
        chk("t6_cursor", {25'd0, cursor}, 32'd0);
        chk("t6_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        repeat (40) @(negedge clk);
        chk("t6_no_strobe", bus_q.size(), 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        send(1'b0, 8'h33);
        chk("t6_new_count", bus_q.size(), 32'd1);
        chk("t6_new_word", {20'd0, bus_q[0]}, 32'h033);
        chk("t6_new_cursor", {25'd0, cursor}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
